// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone classic arbiter for one shared slave.
// Slave no-ack timeout reported to the granted master as a one-cycle err pulse.
module wb_arb2 #(
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [AWIDTH-1:0] m0_adr_i,
  input  logic [31:0]       m0_dat_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [AWIDTH-1:0] m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [AWIDTH-1:0] s_adr_o,
  output logic [31:0]       s_dat_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          stall, tmo;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign gnt_o    = state;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the master that did not hold the bus last wins.
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? G0 : G1;
        else if (m0_cyc_i)        state_nxt = G0;
        else if (m1_cyc_i)        state_nxt = G1;
      end
      G0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        if (!m0_cyc_i) begin
          last_nxt  = 1'b0;
          state_nxt = m1_cyc_i ? G1 : IDLE;
        end
      end
      G1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        if (!m1_cyc_i) begin
          last_nxt  = 1'b1;
          state_nxt = m0_cyc_i ? G0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A stalled cycle is one with an active strobe and no ack, so ack always beats err.
    stall    = s_cyc_o & s_stb_o & ~s_ack_i;
    tmo      = (TIMEOUT != 0) && stall && (cnt == TMO_LAST);
    m0_err_o = (state == G0) && tmo;
    m1_err_o = (state == G1) && tmo;

    if (TIMEOUT == 0 || state_nxt != state || !stall || tmo) cnt_nxt = '0;
    else                                                     cnt_nxt = cnt + 1'b1;
  end
endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: per-cycle model comparison plus literal checks of the key scenarios.
module tb_wb_arb2;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mc[2], ms[2], mw[2];
  logic [3:0]  msel[2];
  logic [31:0] madr[2], mdat[2];
  logic [31:0] sdat;
  logic        sack;

  logic [31:0] m0_dat, m1_dat, s_adr, s_dat;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;

  logic [31:0] z_m0_dat, z_m1_dat, z_s_adr, z_s_dat;
  logic        z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_s_cyc, z_s_stb, z_s_we;
  logic [3:0]  z_s_sel;
  logic [1:0]  z_gnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wb_arb2 #(.AWIDTH(32), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_sel_i(msel[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_sel_i(msel[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
    .s_dat_o(s_dat), .s_dat_i(sdat), .s_ack_i(sack), .gnt_o(gnt)
  );

  // Same stimulus with the timeout disabled; its err outputs must never fire.
  wb_arb2 #(.AWIDTH(32), .TIMEOUT(0)) dut_z (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_sel_i(msel[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(z_m0_dat), .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_sel_i(msel[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(z_m1_dat), .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err),
    .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_we_o(z_s_we), .s_sel_o(z_s_sel), .s_adr_o(z_s_adr),
    .s_dat_o(z_s_dat), .s_dat_i(sdat), .s_ack_i(sack), .gnt_o(z_gnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: owner -1 = idle, else index of granted master; last = master that last released.
  int m_own = -1, m_last = 1, m_cnt = 0;

  initial forever begin
    @(negedge clk or posedge rst);
    if (rst) begin
      m_own = -1; m_last = 1; m_cnt = 0;
    end
    if (!clk) begin
      logic [1:0]   e_gnt;
      logic [72:0]  e_bus;
      logic         stall, err;
      int           nxt;
      e_gnt = (m_own < 0) ? 2'b00 : 2'(1 << m_own);
      e_bus = '0;
      stall = 1'b0;
      if (m_own >= 0) begin
        e_bus = {mc[m_own], ms[m_own], mw[m_own], msel[m_own], madr[m_own], mdat[m_own]};
        stall = mc[m_own] && ms[m_own] && !sack;
      end
      err = stall && (m_cnt == TMO - 1);
      chk("gnt", gnt, e_gnt);
      chk("slave_bus", {s_cyc, s_stb, s_we, s_sel, s_adr, s_dat}, e_bus);
      chk("ack_err", {m0_ack, m0_err, m1_ack, m1_err},
          {m_own == 0 && sack, m_own == 0 && err, m_own == 1 && sack, m_own == 1 && err});
      chk("rd_data", {m0_dat, m1_dat}, {sdat, sdat});
      chk("no_tmo_err", {z_m0_err, z_m1_err}, 2'b00);
      if (!rst) begin
        nxt = m_own;
        if (m_own < 0) begin
          if (mc[0] && mc[1]) nxt = 1 - m_last;
          else if (mc[0])     nxt = 0;
          else if (mc[1])     nxt = 1;
        end else if (!mc[m_own]) begin
          m_last = m_own;
          nxt = mc[1 - m_own] ? 1 - m_own : -1;
        end
        m_cnt = (nxt != m_own || !stall || err) ? 0 : m_cnt + 1;
        m_own = nxt;
      end
    end
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; ms[i] = 0; mw[i] = 0; msel[i] = 4'hF;
    end
    madr[0] = 32'h1000_0010; mdat[0] = 32'hA0A0_0001;
    madr[1] = 32'h2000_0040; mdat[1] = 32'hB1B1_0002;
    msel[1] = 4'h3;
    sdat = 32'h0; sack = 0;
    repeat (2) step();
    #1 chk("rst_gnt", gnt, 2'b00);
    chk("rst_cyc", s_cyc, 1'b0);
    rst = 0;

    // V1: lone m1 request, ack on second granted cycle
    step(); mc[1] = 1; ms[1] = 1; sdat = 32'hDEADBEEF;
    #2 chk("v1_gnt_pre", gnt, 2'b00);
    step(); #2 chk("v1_gnt", gnt, 2'b10);
    chk("v1_noack", m1_ack, 1'b0);
    step(); sack = 1;
    #2 chk("v1_ack", m1_ack, 1'b1);
    chk("v1_dat", m1_dat, 32'hDEADBEEF);
    chk("v1_m0ack", m0_ack, 1'b0);
    step(); sack = 0; mc[1] = 0; ms[1] = 0;

    // V2: simultaneous requests, m0 first, direct handoff
    step(); mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
    #2 chk("v2_gnt_pre", gnt, 2'b00);
    step(); #2 chk("v2_gnt0", gnt, 2'b01);
    step(); mc[0] = 0; ms[0] = 0;
    step(); #2 chk("v2_gnt1", gnt, 2'b10);
    step(); mc[1] = 0; ms[1] = 0;

    // V3: m0 holds the bus for three acked transfers while m1 waits
    step(); mc[0] = 1; ms[0] = 1; mw[0] = 1; mc[1] = 1; ms[1] = 1; sack = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      #2 chk("v3_gnt_hold", gnt, 2'b01);
      chk("v3_ack", m0_ack, 1'b1);
      step();
    end
    mc[0] = 0; ms[0] = 0; mw[0] = 0; sack = 0;
    step(); #2 chk("v3_gnt_m1", gnt, 2'b10);
    step(); mc[1] = 0; ms[1] = 0;

    // V4: m0 stalls, err every fourth stalled cycle
    step(); mc[0] = 1; ms[0] = 1; sdat = 32'h1234_5678;
    step();
    for (int i = 1; i <= 8; i++) begin
      #2 chk("v4_err", m0_err, (i % 4 == 0) ? 1'b1 : 1'b0);
      chk("v4_gnt", gnt, 2'b01);
      step();
    end

    // V5: ack arrives on the would-be timeout cycle
    repeat (3) step();
    sack = 1;
    #2 chk("v5_ack", m0_ack, 1'b1);
    chk("v5_err", m0_err, 1'b0);
    step(); sack = 0; mc[0] = 0; ms[0] = 0;

    // V6: asynchronous reset during an m1 write, m0 pending
    step(); mc[1] = 1; ms[1] = 1; mw[1] = 1;
    step(); mc[0] = 1; ms[0] = 1;
    #1 rst = 1;
    #1 chk("v6_cyc", s_cyc, 1'b0);
    chk("v6_gnt", gnt, 2'b00);
    #1 rst = 0;
    step(); #2 chk("v6_gnt_m0", gnt, 2'b01);
    step();
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; ms[i] = 0; mw[i] = 0;
    end
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
